alu_mult_seq: RTL
=================

Name: alu_mult_seq

Overview:
- Multi-cycle sequencer that computes a 16x16 unsigned shift-and-add multiply using the existing 16-bit Hack ALU.
- Drives the ALU's x/y operands and its six control bits (zx, nx, zy, ny, f, no), and consumes the ALU's combinational out.
- The ALU is instantiated beside this block in the enclosing datapath, not inside it.
- Returns the low 16 bits of the product; these are also correct for two's-complement operands.

Parameters:
- WIDTH, 16, operand/result width; must equal the ALU width; only 16 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- a  in  16  multiplicand, latched on accepted start
- b  in  16  multiplier, latched on accepted start
- busy  out  1  high while stepping
- done  out  1  one-cycle pulse: result valid
- result  out  16  product low half; held until next accepted start
- ovf  out  1  unsigned overflow (see Optional Feature)
- alu_x  out  16  ALU x operand
- alu_y  out  16  ALU y operand
- alu_ctl  out  6  {zx,nx,zy,ny,f,no} to ALU
- alu_out  in  16  ALU result (combinational, same cycle)

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - State = IDLE.
  - busy = 0, done = 0, result = 0, ovf = 0.
  - Internal acc, mcand, mplier = 0; bit counter cnt = 0.
  - alu_x = alu_y = 0; alu_ctl = 6'b101010 (ALU constant 0).
- States: IDLE, ADD, DBL, FIN.
- IDLE:
  - ALU driven with x = y = 0 and ctl = 101010.
  - On start=1: acc <= 0, mcand <= a, mplier <= b, cnt <= 0, ovf <= 0.
  - Next state: FIN if b == 0; else ADD if b[0] = 1; else DBL.
- ADD:
  - alu_x = acc, alu_y = mcand, alu_ctl = 000010 (x+y).
  - acc <= alu_out. Next state: DBL.
- DBL:
  - alu_x = alu_y = mcand, alu_ctl = 000010.
  - mcand <= alu_out, mplier <= mplier >> 1, cnt <= cnt + 1.
  - Let m' = mplier >> 1. Next state is FIN if m' == 0 or cnt == WIDTH-1; else ADD if m'[0] = 1; else DBL.
- FIN:
  - result <= acc, done = 1 for this single cycle, busy = 0.
  - Next state: IDLE.
  - A start arriving in FIN is ignored; it must be reasserted in IDLE.
- busy = 1 exactly in ADD and DBL.
- start in any state other than IDLE is ignored; operands are not re-latched.
- Latency: accept edge, then one cycle per set bit (ADD) plus one cycle per bit position up to the highest set bit of b (DBL), then FIN.
  - Best case b = 0: FIN in the first cycle after acceptance.
  - Worst case b = FFFF: 32 busy cycles, then FIN.
- Arithmetic: all additions are mod 2^16; carries are discarded except as noted under MULT_OVF_EN.
- Reset mid-operation: immediate return to IDLE with all reset values; a partial product is never presented on result.
- result and ovf are stable from FIN until the next accepted start.

Optional Feature:
- Macro: MULT_OVF_EN.
- Defined — ovf is a sticky flag for the current operation, set when any of these occur:
  - in ADD, alu_out < acc (carry out of the add);
  - in DBL, mcand[15] = 1 and m' != 0 (a set bit is shifted out while it would still be added).
  - ovf is registered and updated alongside result in FIN.
- Not defined: ovf is tied to 0 and no overflow logic is synthesised.

Decomposition:
- Shared package/header (alu_ctl_defs), reusable by the future CPU control unit:
  - ALU control constants: ALU_CTL_ZERO = 6'b101010, ALU_CTL_ADD = 6'b000010, ALU_CTL_X = 6'b001100, ALU_CTL_Y = 6'b110000.
  - State encoding (2 bits): IDLE = 0, ADD = 1, DBL = 2, FIN = 3.
- No sub-module: a single FSM plus datapath registers. The ALU instance is connected by the parent.

Test Plan:
- a = 7, b = 6 → DBL, ADD, DBL, ADD, DBL (5 busy cycles); done on the 6th cycle after acceptance; result = 42 (0x002A); ovf = 0.
- a = 0x1234, b = 0 → busy never asserted; done in the 1st cycle after acceptance; result = 0.
- a = 0xFFFF, b = 0xFFFF → 32 busy cycles; result = 0x0001; ovf = 1 with MULT_OVF_EN, 0 without.
- a = 0xFFFD (-3), b = 5 → result = 0xFFF1 (-15); ovf = 1 with the macro; alu_ctl = 000010 on every busy cycle and 101010 in IDLE.
- Mid-operation sequence:
  - start a = 100, b = 0x00FF; pulse start again on busy cycle 3 → ignored; result = 25500 (0x639C).
  - Then drop rst_n on busy cycle 5 → busy, done, result, ovf = 0 immediately, asynchronously.
  - A fresh start after rst_n releases completes normally.
- Back-to-back: assert start on the IDLE cycle right after done → second operation accepted; result holds the first product until the second FIN.

Source files
------------

// File: rtl/alu_ctl_defs.sv
// Shared Hack ALU control words and multiply-sequencer state encoding.
// Reusable by any block that drives the ALU control bits {zx,nx,zy,ny,f,no}.
package alu_ctl_defs;

    localparam logic [5:0] ALU_CTL_ZERO = 6'b101010;
    localparam logic [5:0] ALU_CTL_ADD  = 6'b000010;
    localparam logic [5:0] ALU_CTL_X    = 6'b001100;
    localparam logic [5:0] ALU_CTL_Y    = 6'b110000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DBL  = 2'd2,
        FIN  = 2'd3
    } seqState_e;

endpackage

// File: rtl/alu_mult_seq.sv
// Sequential 16x16 shift-and-add multiplier that borrows the external Hack ALU.
// Ports: clk, rst_n (async low), start/a/b request; busy, done, result, ovf status;
//   alu_x/alu_y/alu_ctl drive the ALU, alu_out is its combinational result.
// Build option: define MULT_OVF_EN to get a sticky unsigned-overflow flag on ovf;
//   otherwise ovf is tied low.
import alu_ctl_defs::*;

module alu_mult_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [5:0]       alu_ctl,
    input  logic [WIDTH-1:0] alu_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    seqState_e state;
    seqState_e stateNext;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        alu_x     = '0;
        alu_y     = '0;
        alu_ctl   = ALU_CTL_ZERO;
        busy      = 1'b0;
        done      = 1'b0;
        mNext     = mplier >> 1;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (b == '0) begin
                        stateNext = FIN;
                    end else if (b[0]) begin
                        stateNext = ADD;
                    end else begin
                        stateNext = DBL;
                    end
                end
            end
            ADD: begin
                alu_x     = acc;
                alu_y     = mcand;
                alu_ctl   = ALU_CTL_ADD;
                busy      = 1'b1;
                stateNext = DBL;
            end
            DBL: begin
                // Doubling is x+x through the ALU; no shifter exists there.
                alu_x   = mcand;
                alu_y   = mcand;
                alu_ctl = ALU_CTL_ADD;
                busy    = 1'b1;
                if (mNext == '0 || cnt == CNT_LAST) begin
                    stateNext = FIN;
                end else if (mNext[0]) begin
                    stateNext = ADD;
                end else begin
                    stateNext = DBL;
                end
            end
            FIN: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= a;
                        mplier <= b;
                        cnt    <= '0;
                    end
                end
                ADD: begin
                    acc <= alu_out;
                end
                DBL: begin
                    mcand  <= alu_out;
                    mplier <= mNext;
                    cnt    <= cnt + 1'b1;
                end
                FIN: begin
                    result <= acc;
                end
            endcase
        end
    end

`ifdef MULT_OVF_EN
    logic ovfSticky;

    // Sticky within one operation; published to ovf together with result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovfSticky <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ovfSticky <= 1'b0;
                        ovf       <= 1'b0;
                    end
                end
                ADD: begin
                    if (alu_out < acc) begin
                        ovfSticky <= 1'b1;
                    end
                end
                DBL: begin
                    // A lost top bit only matters if more partial sums follow.
                    if (mcand[WIDTH-1] && mNext != '0) begin
                        ovfSticky <= 1'b1;
                    end
                end
                FIN: begin
                    ovf <= ovfSticky;
                end
            endcase
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule
